// File: rtl/CPU_package.sv
// Shared CPU types: datapath width and the ALU/logic-unit opcode encoding.
package CPU_package;

  parameter int unsigned DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    ALU_OP_ADD = 4'h0,
    ALU_OP_SUB = 4'h1,
    ALU_OP_AND = 4'h2,
    ALU_OP_OR  = 4'h3,
    ALU_OP_XOR = 4'h4,
    ALU_OP_NOT = 4'h5,
    ALU_OP_CPR = 4'h6,
    ALU_OP_SHL = 4'h7
  } enum_alu_opcode_t;

endpackage

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of a shared logic unit: accept, settle, capture, respond.
// Define LOGIC_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module logic_unit_arbiter
  import CPU_package::*;
#(
  parameter int unsigned DATA_WIDTH = CPU_package::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  enum_alu_opcode_t      req0_opcode,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  enum_alu_opcode_t      req1_opcode,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,

  output logic [DATA_WIDTH-1:0] lu_a,
  output logic [DATA_WIDTH-1:0] lu_b,
  output enum_alu_opcode_t      lu_opcode,
  input  logic [DATA_WIDTH-1:0] lu_out,
  input  logic [2:0]            lu_flag,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [2:0]            rsp_flag,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StExec, StCapt, StResp} state_e;

  state_e state_q, state_d;

  logic                  any_valid;
  logic                  tie_id;
  logic                  gnt_id;
  logic                  accept;

  enum_alu_opcode_t      op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  id_q;

  logic                  rsp_valid_q;
  logic                  rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [2:0]            rsp_flag_q;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [2:0]            cap_flag;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
`ifdef LOGIC_ARB_FIXED_PRIO_EN
  assign tie_id = 1'b0;
`else
  logic last_q;

  // Reset to "1 granted last" so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt_id;
    end
  end

  assign tie_id = ~last_q;
`endif

  assign any_valid = req0_valid | req1_valid;
  assign gnt_id    = (req0_valid && req1_valid) ? tie_id : req1_valid;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StCapt;
      StCapt:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    accept     = (state_q == StIdle) && any_valid;
    // Flops are held by the async reset; only the combinational readies need gating.
    req0_ready = accept && !gnt_id && rst_n;
    req1_ready = accept && gnt_id && rst_n;
    busy       = (state_q != StIdle);
  end

  // ---------------------------------------------------------------------------
  // Command registers; the logic unit only ever sees these.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= enum_alu_opcode_t'('0);
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (accept) begin
      op_q <= gnt_id ? req1_opcode : req0_opcode;
      a_q  <= gnt_id ? req1_a      : req0_a;
      b_q  <= gnt_id ? req1_b      : req0_b;
      id_q <= gnt_id;
    end
  end

  assign lu_a      = a_q;
  assign lu_b      = b_q;
  assign lu_opcode = op_q;

  // ---------------------------------------------------------------------------
  // Response capture and hold
  // ---------------------------------------------------------------------------
  always_comb begin
    cap_data = '0;
    cap_flag = '0;
    case (op_q)
      ALU_OP_CPR: cap_flag = lu_flag;
      ALU_OP_AND,
      ALU_OP_OR,
      ALU_OP_XOR,
      ALU_OP_NOT: cap_data = lu_out;
      default: begin
        cap_data = '0;
        cap_flag = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= '0;
    end else if (state_q == StCapt) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= id_q;
      rsp_data_q  <= cap_data;
      rsp_flag_q  <= cap_flag;
    end else if (state_q == StResp && rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flag  = rsp_flag_q;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));

  a_valid_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid == (state_q == StResp));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=>
      (rsp_valid && $stable(rsp_data) && $stable(rsp_flag) && $stable(rsp_id)));

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter with a behavioural logic-unit model.
module tb_logic_unit_arbiter;
  import CPU_package::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  enum_alu_opcode_t req0_opcode, req1_opcode, lu_opcode;
  logic [7:0]       req0_a, req0_b, req1_a, req1_b;
  logic [7:0]       lu_a, lu_b, lu_out, rsp_data;
  logic [2:0]       lu_flag, rsp_flag;
  logic             rsp_valid, rsp_ready, rsp_id, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_opcode(req0_opcode),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_opcode(req1_opcode),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .lu_a       (lu_a),
    .lu_b       (lu_b),
    .lu_opcode  (lu_opcode),
    .lu_out     (lu_out),
    .lu_flag    (lu_flag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_flag   (rsp_flag),
    .busy       (busy)
  );

  // Logic-unit model: flags always report the compare, out is a+b for non-logic ops,
  // so the arbiter's masking is visible.
  always_comb begin
    lu_out  = lu_a + lu_b;
    lu_flag = 3'b001;
    case (lu_opcode)
      ALU_OP_AND: lu_out = lu_a & lu_b;
      ALU_OP_OR:  lu_out = lu_a | lu_b;
      ALU_OP_XOR: lu_out = lu_a ^ lu_b;
      ALU_OP_NOT: lu_out = ~lu_a;
      default:    lu_out = lu_a + lu_b;
    endcase
    if (lu_a == lu_b)     lu_flag = 3'b100;
    else if (lu_a > lu_b) lu_flag = 3'b010;
    else                  lu_flag = 3'b001;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic id, input enum_alu_opcode_t op,
                           input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0; req0_a = 8'hA5; req0_b = 8'h5A; req0_opcode = ALU_OP_SHL;
    req1_valid = 1'b0; req1_a = 8'hC3; req1_b = 8'h3C; req1_opcode = ALU_OP_SHL;
  endtask

  // Issues one command, checks grant, operand isolation and latency (edges counted
  // from and including the accept edge). Returns at the first RESP cycle.
  task automatic do_cmd(input string tag, input logic id, input enum_alu_opcode_t op,
                        input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] d, output logic [2:0] f, output logic g);
    int c;
    int lat;
    @(negedge clk);
    drive_req(id, op, a, b);
    #1;
    c = 0;
    while (!(req0_ready || req1_ready) && c < 20) begin
      @(negedge clk); #1; c++;
    end
    check_eq({tag, "-rdy"}, 32'({req1_ready, req0_ready}), id ? 32'd2 : 32'd1);
    @(negedge clk);
    clear_reqs();
    #1;
    check_eq({tag, "-busy"}, 32'(busy), 1);
    check_eq({tag, "-lu_a"}, 32'(lu_a), 32'(a));
    check_eq({tag, "-lu_b"}, 32'(lu_b), 32'(b));
    check_eq({tag, "-lu_op"}, 32'(lu_opcode), 32'(op));
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    check_eq({tag, "-lat"}, 32'(lat), 3);
    d = rsp_data;
    f = rsp_flag;
    g = rsp_id;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [2:0] f;
    logic       g;
    logic       exp_id;
    int         c;

    clear_reqs();
    rsp_ready  = 1'b1;
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req0_opcode = ALU_OP_AND;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst-req0_ready", 32'(req0_ready), 0);
    check_eq("rst-rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst-busy", 32'(busy), 0);
    check_eq("rst-rsp_data", 32'(rsp_data), 0);
    check_eq("rst-rsp_flag", 32'(rsp_flag), 0);
    check_eq("rst-rsp_id", 32'(rsp_id), 0);
    check_eq("rst-lu_a", 32'(lu_a), 0);
    check_eq("rst-lu_op", 32'(lu_opcode), 0);
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;

    do_cmd("and", 1'b0, ALU_OP_AND, 8'hF0, 8'h3C, d, f, g);
    check_eq("and-id", 32'(g), 0);
    check_eq("and-data", 32'(d), 'h30);
    check_eq("and-flag", 32'(f), 0);
    @(negedge clk);
    check_eq("and-done-valid", 32'(rsp_valid), 0);
    check_eq("and-done-busy", 32'(busy), 0);

    do_cmd("cpr-eq", 1'b1, ALU_OP_CPR, 8'd5, 8'd5, d, f, g);
    check_eq("cpr-eq-id", 32'(g), 1);
    check_eq("cpr-eq-data", 32'(d), 0);
    check_eq("cpr-eq-flag", 32'(f), 'b100);
    do_cmd("cpr-gt", 1'b1, ALU_OP_CPR, 8'd7, 8'd2, d, f, g);
    check_eq("cpr-gt-data", 32'(d), 0);
    check_eq("cpr-gt-flag", 32'(f), 'b010);
    do_cmd("cpr-lt", 1'b1, ALU_OP_CPR, 8'd1, 8'd9, d, f, g);
    check_eq("cpr-lt-data", 32'(d), 0);
    check_eq("cpr-lt-flag", 32'(f), 'b001);

    do_cmd("not", 1'b0, ALU_OP_NOT, 8'h5A, 8'h00, d, f, g);
    check_eq("not-data", 32'(d), 'hA5);
    check_eq("not-flag", 32'(f), 0);

    do_cmd("add", 1'b0, ALU_OP_ADD, 8'd3, 8'd4, d, f, g);
    check_eq("add-data", 32'(d), 0);
    check_eq("add-flag", 32'(f), 0);
    do_cmd("opF", 1'b1, enum_alu_opcode_t'(4'hF), 8'd9, 8'd9, d, f, g);
    check_eq("opF-data", 32'(d), 0);
    check_eq("opF-flag", 32'(f), 0);
    @(negedge clk);
    check_eq("opF-idle", 32'(busy), 0);

    // Response back-pressure with both requesters pushing.
    rsp_ready = 1'b0;
    do_cmd("stall", 1'b1, ALU_OP_XOR, 8'h0F, 8'hFF, d, f, g);
    check_eq("stall-data", 32'(d), 'hF0);
    check_eq("stall-id", 32'(g), 1);
    drive_req(1'b0, ALU_OP_OR, 8'h11, 8'h22);
    drive_req(1'b1, ALU_OP_OR, 8'h33, 8'h44);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check_eq("stall-valid", 32'(rsp_valid), 1);
      check_eq("stall-hold-data", 32'(rsp_data), 'hF0);
      check_eq("stall-hold-id", 32'(rsp_id), 1);
      check_eq("stall-hold-flag", 32'(rsp_flag), 0);
      check_eq("stall-readies", 32'({req1_ready, req0_ready}), 0);
      check_eq("stall-busy", 32'(busy), 1);
    end
    clear_reqs();
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("stall-rel-valid", 32'(rsp_valid), 0);
    check_eq("stall-rel-busy", 32'(busy), 0);

    // Reset while the command sits in EXEC.
    drive_req(1'b0, ALU_OP_AND, 8'hFF, 8'hFF);
    #1;
    check_eq("rstx-rdy", 32'(req0_ready), 1);
    @(negedge clk);
    clear_reqs();
    #1;
    check_eq("rstx-busy-pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_eq("rstx-valid", 32'(rsp_valid), 0);
    check_eq("rstx-busy", 32'(busy), 0);
    check_eq("rstx-data", 32'(rsp_data), 0);
    check_eq("rstx-flag", 32'(rsp_flag), 0);
    check_eq("rstx-id", 32'(rsp_id), 0);
    check_eq("rstx-lu_a", 32'(lu_a), 0);
    check_eq("rstx-lu_b", 32'(lu_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) c++;
    end
    check_eq("rstx-no-rsp", 32'(c), 0);
    do_cmd("or", 1'b0, ALU_OP_OR, 8'd1, 8'd2, d, f, g);
    check_eq("or-data", 32'(d), 3);
    check_eq("or-flag", 32'(f), 0);
    check_eq("or-id", 32'(g), 0);

    // Fresh reset, then both requesters valid continuously.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(1'b0, ALU_OP_XOR, 8'h33, 8'h0F);
    drive_req(1'b1, ALU_OP_NOT, 8'h81, 8'h00);
    for (int k = 0; k < 4; k++) begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = (k % 2) == 1;
`endif
      #1;
      c = 0;
      while (!(req0_ready || req1_ready) && c < 20) begin
        @(negedge clk); #1; c++;
      end
      check_eq("rr-grant", 32'({req1_ready, req0_ready}), exp_id ? 32'd2 : 32'd1);
      @(negedge clk);
      c = 1;
      while (!rsp_valid && c < 20) begin
        @(negedge clk); c++;
      end
      check_eq("rr-lat", 32'(c), 3);
      check_eq("rr-id", 32'(rsp_id), 32'(exp_id));
      check_eq("rr-data", 32'(rsp_data), exp_id ? 32'h7E : 32'h3C);
      @(negedge clk);
    end
    clear_reqs();
    @(negedge clk);
    check_eq("end-idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
